// File: rtl/sign_extend.sv
// ----------------------------------------------------------------------------
// sign_extend
//
// Immediate generator for the RV32I single-cycle datapath. It pulls the
// immediate field out of a 32-bit instruction word and sign-extends it to
// 32 bits for the ALU / PC adder. The encoding format is chosen by the main
// decoder through ImmSrc. An illegal select produces an all-zero immediate,
// never X. A registered flag also reports the illegal select to debug/trap
// logic.
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset, clears every flop
//   In       in   32  instruction word (In[6:0] opcode is not used here)
//   ImmSrc   in   3   000 I, 001 S, 010 B, 011 U, 100 J, 101..111 illegal
//   Imm_Ext  out  32  extended immediate
//   ImmErr   out  1   illegal ImmSrc was seen on the previous rising edge
//
// Build option
//   SIGN_EXTEND_PIPE_EN : when defined, Imm_Ext comes from a 32-bit register
//                         that reloads on every rising edge (1-cycle latency,
//                         resets to 0). ImmErr timing does not change, so it
//                         lines up with the registered immediate. When the
//                         macro is undefined, Imm_Ext is purely combinational.
// ----------------------------------------------------------------------------
module sign_extend (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] In,
    input  logic [2:0]  ImmSrc,
    output logic [31:0] Imm_Ext,
    output logic        ImmErr
);

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    logic        sign;
    logic        illegal;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_comb;

    // The opcode bits take no part in immediate extraction. Reducing them
    // into a signal named "unused" marks them as intentionally dropped.
    logic        unused_opcode;
    assign unused_opcode = ^In[6:0];

    // Every format takes its sign from In[31].
    assign sign = In[31];

    // Each format is assembled in parallel. The select mux then chooses one.
    // B and J drop bit 0 because branch and jump targets are halfword aligned.
    // U supplies the upper 20 bits directly, so it needs no extension.
    assign imm_i = {{20{sign}}, In[31:20]};
    assign imm_s = {{20{sign}}, In[31:25], In[11:7]};
    assign imm_b = {{19{sign}}, In[31], In[7], In[30:25], In[11:8], 1'b0};
    assign imm_u = {In[31:12], 12'b0};
    assign imm_j = {{11{sign}}, In[31], In[19:12], In[20], In[30:21], 1'b0};

    // Select codes above J are reserved.
    assign illegal = (ImmSrc > IMM_J);

    // Format select. The zero default covers the reserved codes, so an
    // illegal select produces a clean zero instead of X. A legacy 1-bit
    // driver, zero-extended, lands on I or S without special handling.
    always_comb begin
        imm_comb = 32'h0000_0000;
        case (ImmSrc)
            IMM_I:   imm_comb = imm_i;
            IMM_S:   imm_comb = imm_s;
            IMM_B:   imm_comb = imm_b;
            IMM_U:   imm_comb = imm_u;
            IMM_J:   imm_comb = imm_j;
            default: imm_comb = 32'h0000_0000;
        endcase
    end

    // Illegal-select flag. It is sampled every edge, so it stays high while
    // the select stays reserved and clears on the first edge with a legal
    // select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ImmErr <= 1'b0;
        end else begin
            ImmErr <= illegal;
        end
    end

`ifdef SIGN_EXTEND_PIPE_EN
    // Optional output register. It reloads unconditionally every edge, so
    // the immediate and ImmErr both describe the select from the same edge.
    logic [31:0] imm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q <= 32'h0000_0000;
        end else begin
            imm_q <= imm_comb;
        end
    end

    assign Imm_Ext = imm_q;
`else
    assign Imm_Ext = imm_comb;
`endif

endmodule

// File: tb/tb_sign_extend.sv
// ----------------------------------------------------------------------------
// tb_sign_extend
//
// Directed self-checking bench for sign_extend. Expected immediates are
// hand-computed constants. With SIGN_EXTEND_PIPE_EN defined, immediate
// checks wait one rising edge before sampling.
// ----------------------------------------------------------------------------
module tb_sign_extend;

    logic        clk;
    logic        rst_n;
    logic [31:0] In;
    logic [2:0]  ImmSrc;
    logic [31:0] Imm_Ext;
    logic        ImmErr;

    int total;
    int bad;

    sign_extend dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .In      (In),
        .ImmSrc  (ImmSrc),
        .Imm_Ext (Imm_Ext),
        .ImmErr  (ImmErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge. The settle step then lets the
    // result become visible: #1 for the combinational build, or the next
    // rising edge plus #1 for the pipelined build.
    task automatic drive(input logic [31:0] word, input logic [2:0] src);
        @(negedge clk);
        In     = word;
        ImmSrc = src;
    endtask

    task automatic settle();
`ifdef SIGN_EXTEND_PIPE_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        In     = 32'h7FF0_0093;
        ImmSrc = 3'b000;
        @(posedge clk);
        #1;
        total++;
`ifdef SIGN_EXTEND_PIPE_EN
        if (Imm_Ext !== 32'h0000_0000) begin
            bad++;
            $display("[TB] FAIL reset_imm got=%h want=%h", Imm_Ext, 32'h0000_0000);
        end
`else
        if (Imm_Ext !== 32'h0000_07FF) begin
            bad++;
            $display("[TB] FAIL reset_imm got=%h want=%h", Imm_Ext, 32'h0000_07FF);
        end
`endif
        ImmSrc = 3'b101;
        @(posedge clk);
        #1;
        total++;
        if (ImmErr !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_err got=%b want=0", ImmErr);
        end
        @(negedge clk);
        ImmSrc = 3'b000;
        rst_n  = 1'b1;
    endtask

    task automatic test_formats();
        logic [31:0] words [10];
        logic [2:0]  srcs  [10];
        logic [31:0] exps  [10];
        words[0] = 32'h7FF0_0093; srcs[0] = 3'b000; exps[0] = 32'h0000_07FF;
        words[1] = 32'h8000_0093; srcs[1] = 3'b000; exps[1] = 32'hFFFF_F800;
        words[2] = 32'h0000_0FA3; srcs[2] = 3'b001; exps[2] = 32'h0000_001F;
        words[3] = 32'hFE00_0FA3; srcs[3] = 3'b001; exps[3] = 32'hFFFF_FFFF;
        words[4] = 32'hFE00_0EE3; srcs[4] = 3'b010; exps[4] = 32'hFFFF_FFFC;
        words[5] = 32'h1234_5037; srcs[5] = 3'b011; exps[5] = 32'h1234_5000;
        words[6] = 32'h0080_006F; srcs[6] = 3'b100; exps[6] = 32'h0000_0008;
        // Every field bit set: B/J bit 0 and U bits [11:0] must still be zero.
        words[7] = 32'hFFFF_FFFF; srcs[7] = 3'b010; exps[7] = 32'hFFFF_FFFE;
        words[8] = 32'hFFFF_FFFF; srcs[8] = 3'b011; exps[8] = 32'hFFFF_F000;
        words[9] = 32'hFFFF_FFFF; srcs[9] = 3'b100; exps[9] = 32'hFFFF_FFFE;
        for (int i = 0; i < 10; i++) begin
            drive(words[i], srcs[i]);
            settle();
            total++;
            if (Imm_Ext !== exps[i]) begin
                bad++;
                $display("[TB] FAIL format_%0d src=%b in=%h got=%h want=%h",
                         i, srcs[i], words[i], Imm_Ext, exps[i]);
            end
        end
    endtask

    task automatic test_illegal_codes();
        for (int code = 5; code < 8; code++) begin
            drive(32'hFFFF_FFFF, code[2:0]);
            settle();
            total++;
            if (Imm_Ext !== 32'h0000_0000) begin
                bad++;
                $display("[TB] FAIL illegal_imm_%0d got=%h want=%h", code, Imm_Ext, 32'h0000_0000);
            end
        end
    endtask

    task automatic test_illegal_flag();
        drive(32'h0000_0000, 3'b000);
        @(posedge clk);
        drive(32'h8765_4321, 3'b101);
`ifndef SIGN_EXTEND_PIPE_EN
        #1;
        total++;
        if (Imm_Ext !== 32'h0000_0000) begin
            bad++;
            $display("[TB] FAIL illflag_imm0 got=%h want=%h", Imm_Ext, 32'h0000_0000);
        end
`endif
        @(posedge clk);
        #1;
        total++;
        if (ImmErr !== 1'b1) begin
            bad++;
            $display("[TB] FAIL illflag_edge1 got=%b want=1", ImmErr);
        end
        total++;
        if (Imm_Ext !== 32'h0000_0000) begin
            bad++;
            $display("[TB] FAIL illflag_imm1 got=%h want=%h", Imm_Ext, 32'h0000_0000);
        end
        @(posedge clk);
        #1;
        total++;
        if (ImmErr !== 1'b1) begin
            bad++;
            $display("[TB] FAIL illflag_edge2 got=%b want=1", ImmErr);
        end
        drive(32'h7FF0_0093, 3'b000);
        #1;
        total++;
        if (ImmErr !== 1'b1) begin
            bad++;
            $display("[TB] FAIL illflag_hold got=%b want=1", ImmErr);
        end
        @(posedge clk);
        #1;
        total++;
        if (ImmErr !== 1'b0) begin
            bad++;
            $display("[TB] FAIL illflag_clear got=%b want=0", ImmErr);
        end
        total++;
        if (Imm_Ext !== 32'h0000_07FF) begin
            bad++;
            $display("[TB] FAIL illflag_legal_imm got=%h want=%h", Imm_Ext, 32'h0000_07FF);
        end
    endtask

    task automatic test_mid_reset();
        // Case 1: the flag is set, then reset clears it without any clock edge.
        drive(32'h0000_0000, 3'b110);
        @(posedge clk);
        #1;
        total++;
        if (ImmErr !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrst_pre got=%b want=1", ImmErr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ImmErr !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_err got=%b want=0", ImmErr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Case 2: a loaded immediate meets reset. In the combinational build
        // reset has no effect on it; a pipe register must clear at once.
        drive(32'h7FF0_0093, 3'b000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
`ifdef SIGN_EXTEND_PIPE_EN
        if (Imm_Ext !== 32'h0000_0000) begin
            bad++;
            $display("[TB] FAIL midrst_imm got=%h want=%h", Imm_Ext, 32'h0000_0000);
        end
`else
        if (Imm_Ext !== 32'h0000_07FF) begin
            bad++;
            $display("[TB] FAIL midrst_imm got=%h want=%h", Imm_Ext, 32'h0000_07FF);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        // The select changes on every cycle, so each result depends only on
        // the current In/ImmSrc pair.
        drive(32'h8000_0093, 3'b000);
        settle();
        total++;
        if (Imm_Ext !== 32'hFFFF_F800) begin
            bad++;
            $display("[TB] FAIL b2b_i got=%h want=%h", Imm_Ext, 32'hFFFF_F800);
        end
        drive(32'h8000_0093, 3'b011);
        settle();
        total++;
        if (Imm_Ext !== 32'h8000_0000) begin
            bad++;
            $display("[TB] FAIL b2b_u got=%h want=%h", Imm_Ext, 32'h8000_0000);
        end
        drive(32'h8000_0093, 3'b001);
        settle();
        total++;
        if (Imm_Ext !== 32'hFFFF_F801) begin
            bad++;
            $display("[TB] FAIL b2b_s got=%h want=%h", Imm_Ext, 32'hFFFF_F801);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_formats();
        test_illegal_codes();
        test_illegal_flag();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
